// File: rtl/px_source_sequencer.sv
`timescale 1ns/1ps
// px_source_sequencer: chooses SPI pixels or a 16-bit LFSR test pattern for
// the gray/Sobel pipeline, loads seed/stop from a byte port and paces the
// generated stream with a fixed inter-pixel gap.
module px_source_sequencer #(
    parameter int unsigned PX_W       = 24,
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic            clk_i,
    input  logic            nreset_i,
    input  logic            select_input_i,
    input  logic [7:0]      cfg_byte_i,
    input  logic            cfg_valid_i,
    input  logic            start_i,
    input  logic [PX_W-1:0] spi_px_i,
    input  logic            spi_px_rdy_i,
    output logic [PX_W-1:0] px_o,
    output logic            px_rdy_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            cfg_ok_o,
    output logic [15:0]     px_count_o
);

    localparam int unsigned   GW         = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_RELOAD = GW'(GAP_CYCLES - 1);
    localparam int unsigned   REPS       = (PX_W + 15) / 16;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [15:0]       seed_q, seed_d;
    logic [15:0]       stop_q, stop_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic              last_q, last_d;
    logic [PX_W-1:0]   px_q, px_d;
    logic              px_rdy_q, px_rdy_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              cfg_ok_q, cfg_ok_d;
    logic [15:0]       count_q, count_d;
    logic [15:0]       seed_eff;
    logic [15:0]       adv;

    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
    endfunction

    function automatic logic [PX_W-1:0] px_map(input logic [15:0] q);
        logic [REPS*16-1:0] rep;
        rep = {REPS{q}};
        return rep[PX_W-1:0];
    endfunction

    // Next-state, config load, pixel emission and SPI pass-through.
    // lfsr_q holds the value to emit next: the start edge emits seed' directly
    // so the first pulse lands one cycle after start, and the end-of-stream
    // decision is latched in last_q at the emitting edge.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        seed_d   = seed_q;
        stop_d   = stop_q;
        lfsr_d   = lfsr_q;
        gap_d    = gap_q;
        last_d   = last_q;
        px_d     = px_q;
        px_rdy_d = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        cfg_ok_d = cfg_ok_q;
        count_d  = count_q;
        seed_eff = (seed_q == '0) ? 16'h0001 : seed_q;
        adv      = '0;
        unique case (state_q)
            IDLE: begin
                if (start_i && select_input_i && cfg_ok_q) begin
                    adv      = lfsr_next(seed_eff);
                    state_d  = RUN;
                    busy_d   = 1'b1;
                    px_d     = px_map(seed_eff);
                    px_rdy_d = 1'b1;
                    count_d  = 16'd1;
                    lfsr_d   = adv;
                    gap_d    = GAP_RELOAD;
                    last_d   = (seed_eff == stop_q) || (adv == seed_eff);
                end else begin
                    if (cfg_valid_i) begin
                        idx_d = idx_q + 2'd1;
                        case (idx_q)
                            2'd0: begin
                                seed_d[15:8] = cfg_byte_i;
                                cfg_ok_d     = 1'b0;
                            end
                            2'd1: seed_d[7:0]  = cfg_byte_i;
                            2'd2: stop_d[15:8] = cfg_byte_i;
                            2'd3: begin
                                stop_d[7:0] = cfg_byte_i;
                                cfg_ok_d    = 1'b1;
                            end
                        endcase
                    end
                    if (!select_input_i) begin
                        px_rdy_d = spi_px_rdy_i;
                        if (spi_px_rdy_i) begin
                            px_d = spi_px_i;
                        end
                    end
                end
            end
            RUN: begin
                if (!select_input_i) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    last_d  = 1'b0;
                end else if (last_q) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    last_d  = 1'b0;
                end else if (gap_q == '0) begin
                    adv      = lfsr_next(lfsr_q);
                    px_d     = px_map(lfsr_q);
                    px_rdy_d = 1'b1;
                    count_d  = (count_q == 16'hFFFF) ? 16'hFFFF : count_q + 16'd1;
                    lfsr_d   = adv;
                    gap_d    = GAP_RELOAD;
                    last_d   = (lfsr_q == stop_q) || (adv == seed_eff);
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            seed_q   <= '0;
            stop_q   <= '0;
            lfsr_q   <= '0;
            gap_q    <= '0;
            last_q   <= 1'b0;
            px_q     <= '0;
            px_rdy_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cfg_ok_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            seed_q   <= seed_d;
            stop_q   <= stop_d;
            lfsr_q   <= lfsr_d;
            gap_q    <= gap_d;
            last_q   <= last_d;
            px_q     <= px_d;
            px_rdy_q <= px_rdy_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cfg_ok_q <= cfg_ok_d;
            count_q  <= count_d;
        end
    end

    assign px_o       = px_q;
    assign px_rdy_o   = px_rdy_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign cfg_ok_o   = cfg_ok_q;
    assign px_count_o = count_q;

endmodule

// File: tb/tb_px_source_sequencer.sv
`timescale 1ns/1ps
// Bench for px_source_sequencer: a stream-level model predicts every output
// each cycle for the GAP=4 instance; a GAP=1 instance covers the period wrap.
module tb_px_source_sequencer;
    localparam int PX_W = 24;
    localparam int G    = 4;

    logic            clk       = 1'b0;
    logic            nreset    = 1'b0;
    logic            sel       = 1'b0;
    logic            w_sel     = 1'b0;
    logic [7:0]      cfg_byte  = '0;
    logic            cfg_valid = 1'b0;
    logic            start     = 1'b0;
    logic [PX_W-1:0] spi_px    = '0;
    logic            spi_rdy   = 1'b0;

    logic [PX_W-1:0] px, w_px;
    logic            px_rdy, busy, done, cfg_ok;
    logic            w_px_rdy, w_busy, w_done, w_cfg_ok;
    logic [15:0]     count, w_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    px_source_sequencer #(.PX_W(PX_W), .GAP_CYCLES(G)) u_dut (
        .clk_i(clk), .nreset_i(nreset), .select_input_i(sel),
        .cfg_byte_i(cfg_byte), .cfg_valid_i(cfg_valid), .start_i(start),
        .spi_px_i(spi_px), .spi_px_rdy_i(spi_rdy),
        .px_o(px), .px_rdy_o(px_rdy), .busy_o(busy), .done_o(done),
        .cfg_ok_o(cfg_ok), .px_count_o(count)
    );

    px_source_sequencer #(.PX_W(PX_W), .GAP_CYCLES(1)) u_wrap (
        .clk_i(clk), .nreset_i(nreset), .select_input_i(w_sel),
        .cfg_byte_i(cfg_byte), .cfg_valid_i(cfg_valid), .start_i(start),
        .spi_px_i(spi_px), .spi_px_rdy_i(spi_rdy),
        .px_o(w_px), .px_rdy_o(w_px_rdy), .busy_o(w_busy), .done_o(w_done),
        .cfg_ok_o(w_cfg_ok), .px_count_o(w_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] nxt(input logic [15:0] q);
        return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
    endfunction

    function automatic logic [23:0] map24(input logic [15:0] q);
        return {q[7:0], q};
    endfunction

    // ---------------- stream-level model ----------------
    int          cyc = 0;
    logic        m_cfg_ok = 1'b0;
    int          m_nbytes = 0;
    logic [15:0] m_seed = '0, m_stop = '0;
    logic        m_busy = 1'b0;
    int          m_start = 0;
    logic [15:0] m_list[$];
    logic [23:0] exp_px = '0;
    logic        exp_rdy = 1'b0, exp_busy = 1'b0, exp_done = 1'b0;
    logic [15:0] exp_count = '0;

    // Outputs for cycle c follow from the pixel list and the fixed schedule.
    task automatic plan(input int c);
        int k, len;
        k   = c - m_start;
        len = m_list.size();
        if ((k % G) == 0 && (k / G) < len) begin
            exp_rdy   = 1'b1;
            exp_px    = map24(m_list[k / G]);
            exp_count = (k / G + 1 > 65535) ? 16'hFFFF : 16'(k / G + 1);
            exp_busy  = 1'b1;
        end else if (c == m_start + (len - 1) * G + 1) begin
            exp_done = 1'b1;
            exp_busy = 1'b0;
            m_busy   = 1'b0;
        end else begin
            exp_busy = 1'b1;
        end
    endtask

    task automatic build_list();
        logic [15:0] s, v;
        s = (m_seed == 16'h0000) ? 16'h0001 : m_seed;
        v = s;
        m_list.delete();
        for (int i = 0; i < 65536; i++) begin
            m_list.push_back(v);
            if (v == m_stop) break;
            if (nxt(v) == s) break;
            v = nxt(v);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge nreset);
            if (!nreset) begin
                m_cfg_ok = 1'b0; m_nbytes = 0; m_seed = '0; m_stop = '0; m_busy = 1'b0;
                exp_px = '0; exp_rdy = 1'b0; exp_busy = 1'b0; exp_done = 1'b0; exp_count = '0;
            end else begin
                exp_rdy  = 1'b0;
                exp_done = 1'b0;
                if (m_busy) begin
                    if (!sel) begin
                        m_busy   = 1'b0;
                        exp_busy = 1'b0;
                    end else begin
                        plan(cyc + 1);
                    end
                end else if (start && sel && m_cfg_ok) begin
                    build_list();
                    m_start = cyc + 1;
                    m_busy  = 1'b1;
                    plan(cyc + 1);
                end else begin
                    if (cfg_valid) begin
                        case (m_nbytes)
                            0: begin m_seed[15:8] = cfg_byte; m_cfg_ok = 1'b0; end
                            1: m_seed[7:0] = cfg_byte;
                            2: m_stop[15:8] = cfg_byte;
                            default: begin m_stop[7:0] = cfg_byte; m_cfg_ok = 1'b1; end
                        endcase
                        m_nbytes = (m_nbytes + 1) % 4;
                    end
                    if (!sel && spi_rdy) begin
                        exp_rdy = 1'b1;
                        exp_px  = spi_px;
                    end
                end
                cyc++;
            end
        end
    end

    // Per-cycle comparison of the GAP=4 instance against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (nreset) begin
                check("px_o",       32'(px),     32'(exp_px));
                check("px_rdy_o",   32'(px_rdy), 32'(exp_rdy));
                check("busy_o",     32'(busy),   32'(exp_busy));
                check("done_o",     32'(done),   32'(exp_done));
                check("cfg_ok_o",   32'(cfg_ok), 32'(m_cfg_ok));
                check("px_count_o", 32'(count),  32'(exp_count));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_cfg(input logic [7:0] b);
        cfg_byte  = b;
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic load(input logic [15:0] s, input logic [15:0] p);
        send_cfg(s[15:8]);
        send_cfg(s[7:0]);
        send_cfg(p[15:8]);
        send_cfg(p[7:0]);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        logic found;
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (done) found = 1'b1;
        end
        check(name, 32'(found), 32'd1);
    endtask

    initial begin
        logic [15:0] v;
        int npx, mism, gaps;
        logic seen;

        tick(2);
        check("reset px_o",     32'(px),     32'd0);
        check("reset px_rdy_o", 32'(px_rdy), 32'd0);
        check("reset busy_o",   32'(busy),   32'd0);
        check("reset cfg_ok_o", 32'(cfg_ok), 32'd0);
        check("reset count",    32'(count),  32'd0);
        #2 nreset = 1'b1;
        tick(1);

        // Load and short stream
        sel = 1'b1;
        load(16'hACE1, 16'h59C3);
        check("short cfg_ok", 32'(cfg_ok), 32'd1);
        pulse_start();
        check("short px0",   32'(px),     32'hE1ACE1);
        check("short rdy0",  32'(px_rdy), 32'd1);
        check("short busy",  32'(busy),   32'd1);
        tick(4);
        check("short px1",   32'(px),     32'hC359C3);
        check("short rdy1",  32'(px_rdy), 32'd1);
        tick(1);
        check("short done",  32'(done),   32'd1);
        check("short busy0", 32'(busy),   32'd0);
        check("short count", 32'(count),  32'd2);
        tick(2);

        // Stop equals seed
        load(16'h1234, 16'h1234);
        pulse_start();
        check("seq px0",   32'(px),    32'h341234);
        tick(1);
        check("seq done",  32'(done),  32'd1);
        check("seq count", 32'(count), 32'd1);
        tick(2);

        // Zero seed
        load(16'h0000, 16'h0002);
        pulse_start();
        check("zero px0",   32'(px),    32'h010001);
        tick(4);
        check("zero px1",   32'(px),    32'h020002);
        tick(1);
        check("zero done",  32'(done),  32'd1);
        check("zero count", 32'(count), 32'd2);
        tick(2);

        // Config gating
        send_cfg(8'h00);
        send_cfg(8'h05);
        send_cfg(8'h00);
        check("gate cfg_ok0", 32'(cfg_ok), 32'd0);
        pulse_start();
        check("gate no rdy",  32'(px_rdy), 32'd0);
        check("gate no busy", 32'(busy),   32'd0);
        send_cfg(8'h50);
        check("gate cfg_ok1", 32'(cfg_ok), 32'd1);
        pulse_start();
        check("gate px0", 32'(px), 32'h050005);
        send_cfg(8'hAA);
        send_cfg(8'hBB);
        send_cfg(8'hCC);
        send_cfg(8'hDD);
        wait_done(40, "gate done1");
        check("gate count1", 32'(count), 32'd5);
        tick(1);
        pulse_start();
        check("gate rerun px0", 32'(px), 32'h050005);
        wait_done(40, "gate done2");
        check("gate count2", 32'(count), 32'd5);
        tick(1);

        // Abort mid-run
        pulse_start();
        tick(6);
        sel = 1'b0;
        tick(1);
        check("abort busy",  32'(busy),  32'd0);
        check("abort done",  32'(done),  32'd0);
        check("abort count", 32'(count), 32'd2);
        tick(3);

        // SPI pass-through
        spi_px  = 24'hABCDEF;
        spi_rdy = 1'b1;
        tick(1);
        spi_rdy = 1'b0;
        check("spi px",    32'(px),     32'hABCDEF);
        check("spi rdy",   32'(px_rdy), 32'd1);
        tick(1);
        check("spi hold",  32'(px),     32'hABCDEF);
        check("spi rdy0",  32'(px_rdy), 32'd0);

        // Reset mid-stream
        sel = 1'b1;
        pulse_start();
        tick(3);
        #2 nreset = 1'b0;
        #1;
        check("arst px",     32'(px),     32'd0);
        check("arst rdy",    32'(px_rdy), 32'd0);
        check("arst busy",   32'(busy),   32'd0);
        check("arst done",   32'(done),   32'd0);
        check("arst cfg_ok", 32'(cfg_ok), 32'd0);
        check("arst count",  32'(count),  32'd0);
        tick(1);
        #2 nreset = 1'b1;
        tick(1);
        pulse_start();
        check("arst start ignored rdy",  32'(px_rdy), 32'd0);
        check("arst start ignored busy", 32'(busy),   32'd0);
        tick(2);

        // Period wrap on the GAP=1 instance (stop code unreachable)
        sel   = 1'b0;
        w_sel = 1'b1;
        load(16'hACE1, 16'h0000);
        check("wrap cfg_ok", 32'(w_cfg_ok), 32'd1);
        pulse_start();
        v = 16'hACE1; npx = 0; mism = 0; gaps = 0; seen = 1'b0;
        for (int i = 0; i < 70000 && !seen; i++) begin
            if (w_done) begin
                seen = 1'b1;
            end else begin
                if (w_px_rdy) begin
                    if (w_px !== map24(v)) mism++;
                    v = nxt(v);
                    npx++;
                end else begin
                    gaps++;
                end
                @(negedge clk);
            end
        end
        check("wrap done seen", 32'(seen),    32'd1);
        check("wrap pixels",    32'(npx),     32'd65535);
        check("wrap px seq",    32'(mism),    32'd0);
        check("wrap gaps",      32'(gaps),    32'd0);
        check("wrap count",     32'(w_count), 32'hFFFF);
        check("wrap busy",      32'(w_busy),  32'd0);
        tick(1);
        check("wrap done pulse", 32'(w_done), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
